// File: rtl/calc_pkg.sv
`default_nettype none
// ============================================================================
// Module   : calc_pkg (package)
// Purpose  : Definitions shared by the calculator blocks (cmd_interp, ALU,
//            res_fmt_tx). Holds default datapath widths, ASCII codes and the
//            result-formatter state encoding.
// Contents : CALC_WIDTH / CALC_DIGITS defaults, ASCII_* byte constants,
//            fmt_state_t (formatter FSM states), char_kind_t (kind of the
//            byte currently in flight), ascii_digit() helper.
// Revision : 1.0 - initial release
// ============================================================================
package calc_pkg;

    // Default result magnitude width and matching BCD digit count.
    // 10^CALC_DIGITS must exceed 2^CALC_WIDTH-1.
    localparam int CALC_WIDTH  = 16;
    localparam int CALC_DIGITS = 5;

    localparam logic [7:0] ASCII_0     = 8'h30;
    localparam logic [7:0] ASCII_MINUS = 8'h2D;
    localparam logic [7:0] ASCII_E     = 8'h45;
    localparam logic [7:0] ASCII_CR    = 8'h0D;
    localparam logic [7:0] ASCII_LF    = 8'h0A;

    // Encoding is visible on the debug port, so values are fixed explicitly.
    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_CONV  = 4'd1,
        ST_SIGN  = 4'd2,
        ST_DIGIT = 4'd3,
        ST_WAIT  = 4'd4,
        ST_EOL   = 4'd5,
        ST_DONE  = 4'd6
    } fmt_state_t;

    // What the byte currently waiting for tx_done was; decides where WAIT goes.
    typedef enum logic [1:0] {
        CH_SIGN  = 2'd0,
        CH_DIGIT = 2'd1,
        CH_CR    = 2'd2,
        CH_LF    = 2'd3
    } char_kind_t;

    function automatic logic [7:0] ascii_digit(input logic [3:0] nib);
        return ASCII_0 + {4'h0, nib};
    endfunction

endpackage
`default_nettype wire

// File: rtl/bin2bcd_seq.sv
`default_nettype none
// ============================================================================
// Module   : bin2bcd_seq
// Purpose  : Iterative double-dabble binary to BCD converter, one input bit
//            per cycle, WIDTH cycles per conversion.
// Ports    : clk, rst        - clock, synchronous active-high reset
//            load            - start a conversion of din (clears BCD)
//            din [WIDTH]     - binary value, captured on load
//            busy            - conversion in progress
//            done            - high during the final conversion cycle; bcd
//                              holds the finished result from the next cycle
//            bcd [DIGITS*4]  - BCD digits, digit 0 in bits [3:0]
// Revision : 1.0 - initial release
// ============================================================================
module bin2bcd_seq
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  load,
    input  logic [WIDTH-1:0]      din,
    output logic                  busy,
    output logic                  done,
    output logic [DIGITS*4-1:0]   bcd
);

    localparam int              CW     = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH - 1);

    logic [WIDTH-1:0]    r_sh;
    logic [CW-1:0]       r_cnt;
    logic                r_busy;
    logic [DIGITS*4-1:0] r_bcd;
    logic [DIGITS*4-1:0] w_adj;

    // Add-3 correction on every nibble >= 5 before the shift.
    generate
        for (genvar g = 0; g < DIGITS; g++) begin : g_adj
            assign w_adj[g*4 +: 4] = (r_bcd[g*4 +: 4] >= 4'd5) ?
                                     (r_bcd[g*4 +: 4] + 4'd3) : r_bcd[g*4 +: 4];
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh   <= '0;
            r_cnt  <= '0;
            r_busy <= 1'b0;
            r_bcd  <= '0;
        end else if (load) begin
            r_sh   <= din;
            r_cnt  <= '0;
            r_busy <= 1'b1;
            r_bcd  <= '0;
        end else if (r_busy) begin
            // BCD and the remaining binary bits shift as one register: the
            // binary MSB moves into BCD bit 0.
            {r_bcd, r_sh} <= {w_adj, r_sh} << 1;
            r_cnt         <= r_cnt + 1'b1;
            if (r_cnt == C_LAST) begin
                r_busy <= 1'b0;
            end
        end
    end

    assign busy = r_busy;
    assign done = r_busy && (r_cnt == C_LAST);
    assign bcd  = r_bcd;

endmodule
`default_nettype wire

// File: rtl/res_fmt_tx.sv
`default_nettype none
// ============================================================================
// Module   : res_fmt_tx
// Purpose  : Formats a finished ALU result as unsigned decimal ASCII ('-'
//            prefix when negative, 'E' alone on error, leading zeros
//            suppressed) and streams it to the UART TX one byte at a time.
// Ports    : clk, rst           - clock, synchronous active-high reset
//            start              - request, accepted only while rdy=1
//            res [WIDTH]        - result magnitude (captured on start)
//            neg, err           - sign / error flags (captured on start)
//            tx_done            - UART TX finished the current byte
//            data [8]           - byte to send, held until tx_done
//            tx_start           - one-cycle strobe: data valid
//            rdy                - high only in IDLE
//            debug [8]          - {state, digit_idx}
// Options  : RES_FMT_EOL_EN     - append CR LF after the last character
// Revision : 1.0 - initial release
// ============================================================================
module res_fmt_tx
    import calc_pkg::*;
#(
    parameter int WIDTH  = CALC_WIDTH,
    parameter int DIGITS = CALC_DIGITS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [WIDTH-1:0]  res,
    input  logic              neg,
    input  logic              err,
    input  logic              tx_done,
    output logic [7:0]        data,
    output logic              tx_start,
    output logic              rdy,
    output logic [7:0]        debug
);

    fmt_state_t          r_state;
    char_kind_t          r_kind;
    logic [3:0]          r_digit_idx;
    logic                r_neg;
    logic                r_err;
    logic                r_first;

    logic                w_load;
    logic                w_conv_busy;
    logic                w_conv_done;
    logic [DIGITS*4-1:0] w_bcd;
    logic [3:0]          w_msd;
    logic [3:0]          w_cur_idx;
    logic [3:0]          w_nib;
    fmt_state_t          w_after_last;

    // Conversion is only needed for numeric results.
    assign w_load = start && (r_state == ST_IDLE) && !err;

    bin2bcd_seq #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) u_bin2bcd (
        .clk   (clk),
        .rst   (rst),
        .load  (w_load),
        .din   (res),
        .busy  (w_conv_busy),
        .done  (w_conv_done),
        .bcd   (w_bcd)
    );

    // Most significant non-zero digit; 0 when the whole value is zero so a
    // single '0' goes out.
    always_comb begin
        w_msd = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_bcd[i*4 +: 4] != 4'd0) begin
                w_msd = 4'(i);
            end
        end
    end

    // The first digit of a number uses the leading-zero scan directly, since
    // BCD only becomes final on the edge that enters DIGIT.
    assign w_cur_idx = r_first ? w_msd : r_digit_idx;

    always_comb begin
        w_nib = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (w_cur_idx == 4'(i)) begin
                w_nib = w_bcd[i*4 +: 4];
            end
        end
    end

`ifdef RES_FMT_EOL_EN
    assign w_after_last = ST_EOL;
`else
    assign w_after_last = ST_DONE;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_kind      <= CH_SIGN;
            r_digit_idx <= 4'd0;
            r_neg       <= 1'b0;
            r_err       <= 1'b0;
            r_first     <= 1'b0;
            data        <= 8'h00;
            tx_start    <= 1'b0;
            rdy         <= 1'b1;
        end else begin
            tx_start <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_neg       <= neg;
                        r_err       <= err;
                        r_digit_idx <= 4'd0;
                        rdy         <= 1'b0;
                        r_state     <= err ? ST_SIGN : ST_CONV;
                    end
                end
                ST_CONV: begin
                    if (w_conv_busy && w_conv_done) begin
                        r_first <= 1'b1;
                        r_state <= r_neg ? ST_SIGN : ST_DIGIT;
                    end
                end
                ST_SIGN: begin
                    data     <= r_err ? ASCII_E : ASCII_MINUS;
                    tx_start <= 1'b1;
                    r_kind   <= CH_SIGN;
                    r_state  <= ST_WAIT;
                end
                ST_DIGIT: begin
                    data        <= ascii_digit(w_nib);
                    tx_start    <= 1'b1;
                    r_digit_idx <= w_cur_idx;
                    r_first     <= 1'b0;
                    r_kind      <= CH_DIGIT;
                    r_state     <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (tx_done) begin
                        case (r_kind)
                            CH_SIGN: begin
                                r_state <= r_err ? w_after_last : ST_DIGIT;
                            end
                            CH_DIGIT: begin
                                if (r_digit_idx == 4'd0) begin
                                    r_state <= w_after_last;
                                end else begin
                                    r_digit_idx <= r_digit_idx - 4'd1;
                                    r_state     <= ST_DIGIT;
                                end
                            end
`ifdef RES_FMT_EOL_EN
                            CH_CR:   r_state <= ST_EOL;
                            CH_LF:   r_state <= ST_DONE;
`endif
                            default: r_state <= ST_DONE;
                        endcase
                    end
                end
`ifdef RES_FMT_EOL_EN
                ST_EOL: begin
                    // CR follows the last character, LF follows CR.
                    tx_start <= 1'b1;
                    r_state  <= ST_WAIT;
                    if (r_kind == CH_CR) begin
                        data   <= ASCII_LF;
                        r_kind <= CH_LF;
                    end else begin
                        data   <= ASCII_CR;
                        r_kind <= CH_CR;
                    end
                end
`endif
                ST_DONE: begin
                    rdy     <= 1'b1;
                    r_state <= ST_IDLE;
                end
                default: begin
                    rdy     <= 1'b1;
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign debug = {r_state, r_digit_idx};

endmodule
`default_nettype wire

// File: tb/tb_res_fmt_tx.sv
`default_nettype none
// ============================================================================
// Module   : tb_res_fmt_tx
// Purpose  : Self-checking bench for res_fmt_tx. Expected byte streams come
//            from a decimal-string model of each result; a UART stand-in
//            answers every tx_start with tx_done after a set delay.
// Options  : RES_FMT_EOL_EN     - model appends CR LF when defined
// Revision : 1.0 - initial release
// ============================================================================
module tb_res_fmt_tx;

    localparam int WIDTH  = 16;
    localparam int DIGITS = 5;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [WIDTH-1:0] res;
    logic             neg;
    logic             err;
    logic             tx_done;
    logic [7:0]       data;
    logic             tx_start;
    logic             rdy;
    logic [7:0]       debug;

    logic             resp_done = 1'b0;
    logic             stray_done;
    int               resp_cnt = 0;
    int               resp_delay = 10;
    logic             prev_ts = 1'b0;
    int               consec = 0;
    int               overlap = 0;
    int               unstable = 0;
    int               first_cyc = -1;
    int               cyc = 0;
    logic [7:0]       cap[$];

    int               checks = 0;
    int               errors = 0;

    assign tx_done = resp_done | stray_done;

    res_fmt_tx #(
        .WIDTH  (WIDTH),
        .DIGITS (DIGITS)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .res      (res),
        .neg      (neg),
        .err      (err),
        .tx_done  (tx_done),
        .data     (data),
        .tx_start (tx_start),
        .rdy      (rdy),
        .debug    (debug)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Byte capture plus UART stand-in, sampled on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            resp_cnt  = 0;
            resp_done = 1'b0;
            prev_ts   = 1'b0;
        end else begin
            resp_done = 1'b0;
            if (tx_start) begin
                cap.push_back(data);
                if (first_cyc < 0) first_cyc = cyc;
                if (prev_ts) consec++;
                if (resp_cnt > 0) overlap++;
            end
            prev_ts = tx_start;
            if (resp_cnt > 0) begin
                resp_cnt--;
                if (resp_cnt == 0) begin
                    resp_done = 1'b1;
                    if (cap.size() > 0 && data !== cap[$]) unstable++;
                end
            end else if (tx_start) begin
                resp_cnt = resp_delay;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected bytes straight from the decimal text of the result.
    task automatic build_exp(input logic [15:0] r, input logic n, input logic e,
                             output logic [7:0] q[$]);
        int          v;
        logic [7:0]  rev[$];
        q = {};
        if (e) begin
            q.push_back(8'h45);
        end else begin
            if (n) q.push_back(8'h2D);
            v = int'(r);
            do begin
                rev.push_front(8'(8'h30 + v % 10));
                v = v / 10;
            end while (v != 0);
            foreach (rev[i]) q.push_back(rev[i]);
        end
`ifdef RES_FMT_EOL_EN
        q.push_back(8'h0D);
        q.push_back(8'h0A);
`endif
    endtask

    task automatic run_txn(input logic [15:0] r, input logic n, input logic e,
                           input int d, input bit poke, input bit lat, input string nm);
        logic [7:0] exp[$];
        int         k;
        int         acc;
        build_exp(r, n, e, exp);
        k = 0;
        while (!rdy && k < 100) begin @(negedge clk); k++; end
        resp_delay = d;
        cap.delete();
        first_cyc  = -1;
        res = r; neg = n; err = e; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        acc   = cyc;
        res   = WIDTH'($urandom);
        neg   = 1'($urandom);
        err   = 1'($urandom);
        chk({nm, "_rdy_busy"}, 32'(rdy), 32'd0);
        if (poke) begin
            k = 0;
            while (cap.size() == 0 && k < 200) begin @(negedge clk); k++; end
            @(negedge clk);
            res = 16'd999; neg = 1'b0; err = 1'b0; start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end
        k = 0;
        while (!rdy && k < 3000) begin @(negedge clk); k++; end
        chk({nm, "_timeout"}, 32'(k < 3000), 32'd1);
        chk({nm, "_idle_state"}, 32'(debug[7:4]), 32'd0);
        if (poke) begin
            repeat (40) @(negedge clk);
            chk({nm, "_still_idle"}, 32'(rdy), 32'd1);
        end
        chk({nm, "_nbytes"}, 32'(cap.size()), 32'(exp.size()));
        foreach (exp[i]) begin
            if (i < cap.size()) chk($sformatf("%s_byte%0d", nm, i), 32'(cap[i]), 32'(exp[i]));
        end
        if (lat) chk({nm, "_latency"}, 32'(first_cyc - acc), 32'(WIDTH + 1));
    endtask

    initial begin
        int k;
        rst = 1'b1; start = 1'b0; res = '0; neg = 1'b0; err = 1'b0; stray_done = 1'b0;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_data", 32'(data), 32'h00);
        chk("rst_tx_start", 32'(tx_start), 32'd0);
        chk("rst_rdy", 32'(rdy), 32'd1);
        chk("rst_debug", 32'(debug), 32'h00);
        rst = 1'b0;
        @(negedge clk);

        // Directed results
        run_txn(16'd60,    1'b0, 1'b0, 10, 1'b0, 1'b1, "r60");
        run_txn(16'd0,     1'b0, 1'b0, 10, 1'b0, 1'b1, "r0");
        run_txn(16'd65535, 1'b0, 1'b0, 10, 1'b0, 1'b1, "rmax");
        run_txn(16'd7,     1'b1, 1'b0, 10, 1'b0, 1'b0, "neg7");
        run_txn(16'd123,   1'b0, 1'b1, 10, 1'b0, 1'b0, "err");
        run_txn(16'd10000, 1'b0, 1'b0, 3,  1'b0, 1'b1, "r10000");
        run_txn(16'd4321,  1'b0, 1'b0, 10, 1'b1, 1'b0, "poke");

        // Reset while a byte is outstanding
        resp_delay = 50;
        cap.delete();
        res = 16'd12345; neg = 1'b0; err = 1'b0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        k = 0;
        while (cap.size() == 0 && k < 200) begin @(negedge clk); k++; end
        chk("rstw_reached_wait", 32'(cap.size()), 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("rstw_rdy", 32'(rdy), 32'd1);
        chk("rstw_tx_start", 32'(tx_start), 32'd0);
        chk("rstw_data", 32'(data), 32'h00);
        chk("rstw_debug", 32'(debug), 32'h00);
        @(negedge clk);
        rst = 1'b0;
        cap.delete();
        repeat (5) @(negedge clk);
        stray_done = 1'b1;
        @(negedge clk);
        stray_done = 1'b0;
        repeat (30) @(negedge clk);
        chk("stray_nbytes", 32'(cap.size()), 32'd0);
        chk("stray_rdy", 32'(rdy), 32'd1);
        chk("stray_data", 32'(data), 32'h00);

        run_txn(16'd60, 1'b0, 1'b0, 10, 1'b0, 1'b1, "after_rst");

        // Randomized results
        for (int t = 0; t < 20; t++) begin
            logic [15:0] rv;
            logic        nv;
            logic        ev;
            rv = 16'($urandom_range(0, 65535));
            if (t % 4 == 1) rv = 16'($urandom_range(0, 99));
            nv = 1'($urandom_range(0, 1));
            ev = ($urandom_range(0, 7) == 0);
            run_txn(rv, nv, ev, int'($urandom_range(1, 12)), 1'b0, !nv && !ev,
                    $sformatf("rnd%0d", t));
        end

        chk("no_back_to_back", 32'(consec), 32'd0);
        chk("one_outstanding", 32'(overlap), 32'd0);
        chk("data_stable", 32'(unstable), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/res_fmt_tx.md
Name: res_fmt_tx

Overview:
- Return path of the calculator. Takes the binary ALU result for a finished command and converts it to unsigned decimal ASCII.
- Streams the characters one byte at a time to the UART transmitter through a start/done byte handshake.
- This is the counterpart of the command interpreter, which assembles operands from incoming ASCII bytes.
- Sits between the ALU output register and the UART TX.

Parameters:
- WIDTH, 16, result magnitude width in bits.
- DIGITS, 5, number of BCD digits; must satisfy 10^DIGITS > 2^WIDTH-1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle request to format and send res/neg/err; sampled only when rdy=1.
- res  input  WIDTH  result magnitude, captured on accepted start.
- neg  input  1  result is negative; emit '-' (0x2D) first. Captured on start.
- err  input  1  error result (e.g. divide by zero); emit 'E' (0x45) only. Has priority over res/neg.
- tx_done  input  1  one-cycle pulse from UART TX: current byte fully sent.
- data  output  8  ASCII byte to transmit; stable from tx_start until tx_done.
- tx_start  output  1  one-cycle strobe: data valid, begin transmission.
- rdy  output  1  high only in IDLE.
- debug  output  8  {state[3:0], digit_idx[3:0]}.

Behaviour:
- Reset values: data=0x00, tx_start=0, rdy=1, debug=0x00. FSM returns to IDLE and the BCD register clears.
- rst wins over every other input in the same cycle. Reset mid-byte drops the byte immediately; any later tx_done is ignored.
- States: IDLE, CONV, SIGN, DIGIT, WAIT, EOL, DONE.
- IDLE:
  - start && rdy: capture res, neg, err.
  - If err: go to SIGN with data='E'.
  - Otherwise: go to CONV, clear BCD, counter=0.
  - start while rdy=0 is ignored, with no queuing.
- CONV:
  - Iterative double-dabble, one input bit per cycle, exactly WIDTH cycles.
  - Each cycle: add 3 to every BCD nibble >=5, then shift left with the next res MSB.
  - Exit to SIGN when neg=1, otherwise to DIGIT.
- SIGN:
  - Drive data (neg: '-'; err: 'E') and pulse tx_start for one cycle, then go to WAIT.
  - After err the next state is EOL or DONE; digits are skipped.
- Leading-zero suppression:
  - digit_idx starts at the most significant non-zero digit.
  - If all digits are zero, a single '0' is sent.
- DIGIT:
  - data = 0x30 + BCD[digit_idx]; pulse tx_start one cycle; go to WAIT.
- WAIT:
  - Hold data; tx_start=0.
  - On tx_done, advance to the next char: next digit, then EOL or DONE after digit 0.
  - No timeout. tx_done arriving in the same cycle as tx_start is illegal. A tx_done in any other state is ignored.
- DONE: one cycle, then IDLE; rdy rises the cycle after DONE.
- tx_start is never asserted on two consecutive cycles. At most one byte is outstanding.
- Latency, non-negative non-error case: start accepted at edge N; first tx_start is high in cycle N+WIDTH+1.
- Example: res=60, neg=0 sends 0x36 then 0x30.

Optional Feature:
- Macro: RES_FMT_EOL_EN.
- Defined: after the last character, EOL sends 0x0D then 0x0A, each with its own tx_start/tx_done handshake, then goes to DONE.
- Undefined: EOL state is absent and the last character goes straight to DONE.

Decomposition:
- Shared package calc_pkg:
  - state encoding constants.
  - ASCII constants: ASCII_0=0x30, ASCII_MINUS=0x2D, ASCII_E=0x45, ASCII_CR=0x0D, ASCII_LF=0x0A.
  - WIDTH/DIGITS defaults shared with cmd_interp and the ALU.
- One sub-module: bin2bcd_seq.
  - Iterative double-dabble with load/busy/done; WIDTH cycles; outputs DIGITS*4 bits.
  - The FSM in res_fmt_tx handles sequencing and the handshake.

Test Plan:
- res=60, neg=0, err=0; tx_done 10 cycles after each tx_start -> bytes 0x36, 0x30. rdy=0 throughout, rdy=1 after DONE. First tx_start in cycle N+17.
- res=0 -> single byte 0x30.
- res=65535 -> 0x36, 0x35, 0x35, 0x33, 0x35.
- res=7, neg=1 -> 0x2D, 0x37.
- err=1, res=123 -> 0x45 only. With RES_FMT_EOL_EN: 0x45, 0x0D, 0x0A.
- Second start pulsed while a byte is in WAIT -> ignored, output stream unchanged.
- rst asserted in WAIT -> next cycle rdy=1, tx_start=0, data=0x00. A later stray tx_done produces nothing.
